exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Accumulator/execute stage sitting directly upstream of the x0-x7 register file.
- Accepts one 8-bit instruction at a time over a valid/ready handshake and reads the addressed register through the file's combinational output.
- Computes results into the 6-bit accumulator x8, and drives regAddr/writeReg back to the file for stores.
- Multi-cycle FSM; one instruction in flight at most.

Parameters:
- DATA_W, 6, accumulator/register width; must equal register file width, >= 5
- ADDR_W, 3, register index width
- INSTR_W, 8, instruction width; op = [7:5], operand = [4:0], reg index = operand[ADDR_W-1:0]

Ports:
- clk  input  1  system clock; all state updates on posedge (register file writes on negedge)
- reset  input  1  asynchronous, active-low reset
- instr  input  INSTR_W  instruction word
- instr_valid  input  1  instr is valid this cycle
- instr_ready  output  1  block can accept an instruction
- regOut  input  DATA_W  combinational read data from register file (registers[regAddr])
- regAddr  output  ADDR_W  register index to file, registered
- writeReg  output  1  register-file write enable, registered
- x8  output  DATA_W  accumulator; write data to register file
- zero  output  1  x8 == 0 after last ALU/load op
- carry  output  1  carry/borrow of last ADD/SUB
- halted  output  1  HALT executed (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; x8=0, regAddr=0, writeReg=0, zero=1, carry=0, halted=0; instr_ready=1 once reset is released.
- States: IDLE, EXEC, WRITE (HALT when the feature is enabled).
- IDLE: instr_ready=1. On a posedge with instr_valid=1:
  - latch instr into the internal IR;
  - regAddr <= instr[2:0];
  - go to EXEC.
  - instr_valid with ready low is ignored (no latching); the source must hold.
- EXEC (1 cycle, instr_ready=0): regOut is now valid for regAddr. On the next posedge, by op:
  - 000 NOP: no change.
  - 001 LDI: x8 <= zero-extend(operand[4:0]).
  - 010 LD: x8 <= regOut.
  - 011 ST: writeReg <= 1; go to WRITE.
  - 100 ADD: {carry, x8} <= x8 + regOut (mod 2^DATA_W).
  - 101 SUB: x8 <= x8 - regOut mod 2^DATA_W; carry <= borrow (x8 < regOut).
  - 110 AND: x8 <= x8 & regOut.
  - 111 XOR: x8 <= x8 ^ regOut.
  - After every op except ST/NOP: zero <= (new x8 == 0). carry changes only on ADD/SUB.
  - Non-ST ops return to IDLE.
- WRITE (1 cycle): writeReg=1 for the full cycle so the file's negedge samples x8 at index regAddr. Next posedge: writeReg <= 0, go to IDLE.
- Throughput: non-ST ops take 2 cycles per instruction; ST takes 3. x8 is updated exactly one cycle after acceptance.
- ST to r0: writeReg still pulses; the file discards it. No special-casing here.
- regAddr holds its last value in IDLE; it is never changed during WRITE.
- Reset asserted mid-EXEC/WRITE: writeReg drops immediately; the instruction is lost; no partial write is guaranteed beyond a negedge already passed.
- Flag behaviour never depends on the regOut value outside EXEC.

Optional Feature:
- Macro: EXEC_HALT_EN
- Defined: op 000 with operand 5'h1F is HALT. From EXEC it goes to the HALT state: halted=1, instr_ready=0, no further acceptance until reset. x8, flags and regAddr are frozen.
- Undefined: every op 000 is NOP; halted is tied to 0; the HALT state does not exist.

Decomposition:
- Shared package exec_pkg:
  - opcode constants (OP_NOP..OP_XOR, HALT operand 5'h1F);
  - state encoding enum (IDLE/EXEC/WRITE/HALT);
  - DATA_W/ADDR_W defaults.
- One combinational sub-module exec_alu: inputs op, x8, regOut, imm; outputs result, carry, zero, write-back-enable. The FSM, IR and flag registers stay in exec_sequencer.

Test Plan:
- Reset released, LDI 5 (8'h25) -> x8=6'd5 one cycle after accept, zero=0; instr_ready low 1 cycle, then high.
- LDI 5; ST r3 (8'h63) -> regAddr=3, writeReg high exactly one cycle; file r3=5; ST r0 (8'h60) -> pulse seen, file r0 stays 0.
- x8=6'd60, r3=6'd10, ADD r3 (8'h83) -> x8=6'd6, carry=1, zero=0; SUB r3 with x8=6 -> x8=6'd60, carry=1.
- x8=5, XOR with r3=5 -> x8=0, zero=1, carry unchanged; instr_valid held during EXEC -> second instruction accepted only when back in IDLE, not duplicated.
- ST r3 accepted, reset pulled low during WRITE -> writeReg=0 asynchronously, x8=0, regAddr=0, instr_ready=1 after release.
- With EXEC_HALT_EN: 8'h1F -> halted=1, instr_ready=0, subsequent LDI ignored; without it: 8'h1F behaves as NOP, halted=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcodes, state encoding and width defaults for the accumulator execute stage.
// The HALT state exists only when EXEC_HALT_EN is defined.
package exec_pkg;

   localparam int DATA_W_DEF  = 6;
   localparam int ADDR_W_DEF  = 3;
   localparam int INSTR_W_DEF = 8;
   localparam int OP_W        = 3;
   localparam int IMM_W       = 5;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;
   localparam logic [OP_W-1:0] OP_LDI = 3'b001;
   localparam logic [OP_W-1:0] OP_LD  = 3'b010;
   localparam logic [OP_W-1:0] OP_ST  = 3'b011;
   localparam logic [OP_W-1:0] OP_ADD = 3'b100;
   localparam logic [OP_W-1:0] OP_SUB = 3'b101;
   localparam logic [OP_W-1:0] OP_AND = 3'b110;
   localparam logic [OP_W-1:0] OP_XOR = 3'b111;

   localparam logic [IMM_W-1:0] HALT_IMM = 5'h1F;

`ifdef EXEC_HALT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WRITE, ST_HALT} state_e;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WRITE} state_e;
`endif

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: computes the new accumulator value and flags for one opcode.
// wb_o marks ops that update x8/zero; carry_en_o marks ops that update carry.
module exec_alu
   import exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] x8_i,
   input  logic [DATA_W-1:0] reg_i,
   input  logic [IMM_W-1:0]  imm_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o,
   output logic              wb_o,
   output logic              carry_en_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // The extra top bit is the carry out for ADD and the borrow for SUB.
   assign sum  = {1'b0, x8_i} + {1'b0, reg_i};
   assign diff = {1'b0, x8_i} - {1'b0, reg_i};

   always_comb begin
      result_o   = x8_i;
      carry_o    = 1'b0;
      wb_o       = 1'b0;
      carry_en_o = 1'b0;
      case (op_i)
         OP_LDI: begin
            result_o = DATA_W'(imm_i);
            wb_o     = 1'b1;
         end
         OP_LD: begin
            result_o = reg_i;
            wb_o     = 1'b1;
         end
         OP_ADD: begin
            result_o   = sum[DATA_W-1:0];
            carry_o    = sum[DATA_W];
            wb_o       = 1'b1;
            carry_en_o = 1'b1;
         end
         OP_SUB: begin
            result_o   = diff[DATA_W-1:0];
            carry_o    = diff[DATA_W];
            wb_o       = 1'b1;
            carry_en_o = 1'b1;
         end
         OP_AND: begin
            result_o = x8_i & reg_i;
            wb_o     = 1'b1;
         end
         OP_XOR: begin
            result_o = x8_i ^ reg_i;
            wb_o     = 1'b1;
         end
         default: ;
      endcase
      zero_o = (result_o == '0);
   end

endmodule

// File: rtl/exec_sequencer.sv
// Accumulator execute stage in front of the x0-x7 register file: one instruction in flight.
// Define EXEC_HALT_EN to make op 000 / operand 5'h1F a sticky HALT.
module exec_sequencer
   import exec_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [DATA_W-1:0]  regOut,
   output logic [ADDR_W-1:0]  regAddr,
   output logic               writeReg,
   output logic [DATA_W-1:0]  x8,
   output logic               zero,
   output logic               carry,
   output logic               halted
);

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [DATA_W-1:0]   x8_q, x8_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;

   logic [OP_W-1:0]     op;
   logic [IMM_W-1:0]    imm;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry, alu_zero, alu_wb, alu_carry_en;

   assign op  = ir_q[INSTR_W-1 -: OP_W];
   assign imm = ir_q[IMM_W-1:0];

   exec_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i       (op),
      .x8_i       (x8_q),
      .reg_i      (regOut),
      .imm_i      (imm),
      .result_o   (alu_res),
      .carry_o    (alu_carry),
      .zero_o     (alu_zero),
      .wb_o       (alu_wb),
      .carry_en_o (alu_carry_en)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         x8_q    <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         x8_q    <= x8_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      x8_d    = x8_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               ir_d    = instr;
               addr_d  = instr[ADDR_W-1:0];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            if (op == OP_ST) begin
               wr_d    = 1'b1;
               state_d = ST_WRITE;
            end else if (alu_wb) begin
               x8_d   = alu_res;
               zero_d = alu_zero;
               if (alu_carry_en) carry_d = alu_carry;
            end
`ifdef EXEC_HALT_EN
            // HALT decodes as a NOP, so accumulator and flags are already untouched.
            if (op == OP_NOP && imm == HALT_IMM) state_d = ST_HALT;
`endif
         end
         ST_WRITE: begin
            wr_d    = 1'b0;
            state_d = ST_IDLE;
         end
`ifdef EXEC_HALT_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign regAddr     = addr_q;
   assign writeReg    = wr_q;
   assign x8          = x8_q;
   assign zero        = zero_q;
   assign carry       = carry_q;
`ifdef EXEC_HALT_EN
   assign halted      = (state_q == ST_HALT);
`else
   assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a negedge-write register file model and a
// scoreboard queue of expected accumulator/flag values.
module tb_exec_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [5:0] regOut;
   logic [2:0] regAddr;
   logic       writeReg;
   logic [5:0] x8;
   logic       zero, carry, halted;

   exec_sequencer dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .regOut(regOut), .regAddr(regAddr),
      .writeReg(writeReg), .x8(x8), .zero(zero), .carry(carry), .halted(halted)
   );

   always #5 clk = ~clk;

   // Register file environment: combinational read, negedge write, r0 hardwired to zero.
   logic [5:0] rf [8] = '{default: 6'd0};
   assign regOut = rf[regAddr];
   always @(negedge clk) if (writeReg && regAddr != 3'd0) rf[regAddr] <= x8;

   typedef struct {
      logic [5:0] x8;
      logic       z;
      logic       c;
   } exp_t;
   exp_t sb[$];

   int n_total = 0;
   int n_pass  = 0;

   logic [5:0] m_x8;
   logic       m_zero, m_carry, m_halt;
   logic [5:0] m_regs [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Presents ins with valid high until accepted (bounded); leaves valid to the caller.
   task automatic issue(input logic [7:0] ins, output bit acc);
      acc         = 1'b0;
      instr       = ins;
      instr_valid = 1'b1;
      for (int n = 0; n < 8 && !acc; n++) begin
         if (instr_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic exec_instr(input string tag, input logic [7:0] ins, input bit hold);
      logic [2:0] op, idx;
      logic [5:0] rv;
      logic [6:0] s;
      exp_t       e;
      bit         acc;
      op  = ins[7:5];
      idx = ins[2:0];
      rv  = m_regs[idx];
      case (op)
         3'b001: m_x8 = {1'b0, ins[4:0]};
         3'b010: m_x8 = rv;
         3'b011: if (idx != 3'd0) m_regs[idx] = m_x8;
         3'b100: begin s = {1'b0, m_x8} + {1'b0, rv}; m_x8 = s[5:0]; m_carry = s[6]; end
         3'b101: begin m_carry = (m_x8 < rv); m_x8 = m_x8 - rv; end
         3'b110: m_x8 = m_x8 & rv;
         3'b111: m_x8 = m_x8 ^ rv;
         default: ;
      endcase
      if (op != 3'b000 && op != 3'b011) m_zero = (m_x8 == 6'd0);
`ifdef EXEC_HALT_EN
      if (ins == 8'h1F) m_halt = 1'b1;
`endif
      e.x8 = m_x8; e.z = m_zero; e.c = m_carry;
      sb.push_back(e);

      issue(ins, acc);
      if (!hold) instr_valid = 1'b0;
      chk({tag, ".accept"}, acc, 1);
      chk({tag, ".ready_exec"}, instr_ready, 0);
      chk({tag, ".regAddr"}, regAddr, idx);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      e = sb.pop_front();
      chk({tag, ".x8"}, x8, e.x8);
      chk({tag, ".zero"}, zero, e.z);
      chk({tag, ".carry"}, carry, e.c);
      if (op == 3'b011) begin
         chk({tag, ".wr_high"}, writeReg, 1);
         chk({tag, ".ready_write"}, instr_ready, 0);
         @(posedge clk); #1;
         chk({tag, ".wr_low"}, writeReg, 0);
         chk({tag, ".file"}, rf[idx], m_regs[idx]);
      end
      chk({tag, ".ready_after"}, instr_ready, !m_halt);
      chk({tag, ".halted"}, halted, m_halt);
      if (hold) begin
         @(posedge clk); #1;
         chk({tag, ".no_dup"}, x8, e.x8);
      end
   endtask

   initial begin
      bit acc;
      reset = 1'b0; instr = 8'h00; instr_valid = 1'b0;
      m_x8 = 6'd0; m_zero = 1'b1; m_carry = 1'b0; m_halt = 1'b0;
      m_regs = '{default: 6'd0};
      repeat (2) @(posedge clk);
      #1;
      chk("rst.x8", x8, 0);
      chk("rst.regAddr", regAddr, 0);
      chk("rst.writeReg", writeReg, 0);
      chk("rst.zero", zero, 1);
      chk("rst.carry", carry, 0);
      chk("rst.halted", halted, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst.ready", instr_ready, 1);

      exec_instr("ldi5", 8'h25, 0);
      exec_instr("st_r3", 8'h63, 0);
      exec_instr("st_r0", 8'h60, 0);
      exec_instr("ldi30", 8'h3E, 0);
      exec_instr("st_r1", 8'h61, 0);
      exec_instr("add_r1", 8'h81, 0);
      exec_instr("ldi10", 8'h2A, 0);
      exec_instr("st_r3b", 8'h63, 0);
      exec_instr("ldi30b", 8'h3E, 0);
      exec_instr("add_r1b", 8'h81, 0);
      exec_instr("add_r3", 8'h83, 0);
      exec_instr("sub_r3", 8'hA3, 0);
      exec_instr("ldi5b", 8'h25, 0);
      exec_instr("st_r2", 8'h62, 0);
      exec_instr("xor_r2", 8'hE2, 0);
      exec_instr("ldi7", 8'h27, 0);
      exec_instr("and_r2", 8'hC2, 0);
      exec_instr("ld_r3", 8'h43, 0);
      exec_instr("sub_r2", 8'hA2, 0);
      exec_instr("nop", 8'h00, 0);
      exec_instr("add_hold", 8'h82, 1);

      // Reset asserted mid-WRITE, before the file's negedge samples the store.
      exec_instr("ldi9", 8'h29, 0);
      issue(8'h64, acc);
      instr_valid = 1'b0;
      chk("rstw.accept", acc, 1);
      @(posedge clk); #1;
      chk("rstw.wr_high", writeReg, 1);
      #2 reset = 1'b0;
      #1;
      chk("rstw.wr_async", writeReg, 0);
      chk("rstw.x8", x8, 0);
      chk("rstw.regAddr", regAddr, 0);
      chk("rstw.zero", zero, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      m_x8 = 6'd0; m_zero = 1'b1; m_carry = 1'b0;
      @(posedge clk); #1;
      chk("rstw.ready", instr_ready, 1);
      chk("rstw.file_r4", rf[4], 0);

      exec_instr("halt_op", 8'h1F, 0);
`ifdef EXEC_HALT_EN
      issue(8'h21, acc);
      instr_valid = 1'b0;
      chk("halt.ignored", acc, 0);
      chk("halt.x8_frozen", x8, m_x8);
      chk("halt.still", halted, 1);
`else
      exec_instr("after_nop", 8'h21, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
